// File: rtl/sar_adc_ctrl.sv
// ============================================================================
//  Module      : sar_adc_ctrl
//  Description : Successive-approximation controller for an N-bit SAR ADC.
//                It sequences the sample and binary-search phases, drives the
//                trial code to the DAC and pulses done when the result is ready.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sar_adc_ctrl #(
    parameter int SIZE = 8
) (
    input  logic            clock,
    input  logic            resetb,
    input  logic            start,
    input  logic            cmp_int,
    input  logic            cmp_ext,
    input  logic            cmp_sel,
    output logic [SIZE-1:0] data_out,
    output logic            done,
    output logic            q_out,
    output logic            sample,
    output logic            busy
);

    localparam int IW = (SIZE > 1) ? $clog2(SIZE) : 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SAMPLE = 2'd1;
    localparam logic [1:0] S_CONV   = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [SIZE-1:0] data_q,  data_d;
    logic [IW-1:0]   idx_q,   idx_d;
    logic            sync1_q, start_s_q;
    logic            cmp;

    assign q_out    = cmp_sel ? cmp_ext : cmp_int;
    assign cmp      = q_out;
    assign data_out = data_q;

    // State register, datapath registers and the two-flop start synchroniser
    always_ff @(posedge clock) begin
        if (!resetb) begin
            state_q   <= S_IDLE;
            data_q    <= '0;
            idx_q     <= IW'(SIZE - 1);
            sync1_q   <= 1'b0;
            start_s_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            idx_q     <= idx_d;
            sync1_q   <= start;
            start_s_q <= sync1_q;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        idx_d   = idx_q;
        case (state_q)
            S_IDLE: begin
                if (start_s_q) begin
                    state_d = S_SAMPLE;
                    data_d  = '0;
                end
            end
            S_SAMPLE: begin
                data_d          = '0;
                data_d[SIZE-1]  = 1'b1;
                idx_d           = IW'(SIZE - 1);
                state_d         = S_CONV;
            end
            S_CONV: begin
                // Keep the trial bit only when the input is above the DAC level
                if (!cmp) begin
                    data_d[idx_q] = 1'b0;
                end
                if (idx_q != '0) begin
                    data_d[idx_q - IW'(1)] = 1'b1;
                    idx_d                  = idx_q - IW'(1);
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        done   = (state_q == S_DONE);
        sample = (state_q == S_SAMPLE);
        busy   = (state_q != S_IDLE);
    end

endmodule

`default_nettype wire

// File: tb/tb_sar_adc_ctrl.sv
// ============================================================================
//  Module      : tb_sar_adc_ctrl
//  Description : Directed self-checking bench for sar_adc_ctrl with a
//                behavioural comparator model (VREF = 1.8 V, SIZE = 8).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sar_adc_ctrl;

    logic       clock = 1'b0;
    logic       resetb;
    logic       start;
    logic       cmp_int;
    logic       cmp_ext;
    logic       cmp_sel;
    logic [7:0] data_out;
    logic       done;
    logic       q_out;
    logic       sample;
    logic       busy;

    int   vin_uv;
    logic cmp_model;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clock = ~clock;

    // Input above DAC level, in microvolts: vin > code * 1.8 V / 256
    assign cmp_model = (longint'(vin_uv) * 256) > (longint'(data_out) * 1800000);
    // The unselected comparator carries an opposing value so a wrong select shows up
    assign cmp_ext   = cmp_sel ? cmp_model : 1'b0;
    assign cmp_int   = cmp_sel ? ~cmp_model : cmp_model;

    sar_adc_ctrl #(.SIZE(8)) dut (
        .clock    (clock),
        .resetb   (resetb),
        .start    (start),
        .cmp_int  (cmp_int),
        .cmp_ext  (cmp_ext),
        .cmp_sel  (cmp_sel),
        .data_out (data_out),
        .done     (done),
        .q_out    (q_out),
        .sample   (sample),
        .busy     (busy)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One conversion from an idle controller; start held until done falls
    task automatic run_conv(input int vin, input logic [7:0] exp, input bit chk_trials);
        logic [7:0] trials [8];
        logic [7:0] exp_tr [8];
        int lat;
        int nsamp;
        int nt;
        exp_tr = '{8'h80, 8'h40, 8'h20, 8'h30, 8'h28, 8'h24, 8'h26, 8'h25};
        lat   = 0;
        nsamp = 0;
        nt    = 0;
        vin_uv = vin;
        start  = 1'b1;
        for (int e = 1; e <= 40; e++) begin
            tick();
            if (sample) nsamp++;
            else if (busy && !done && nt < 8) begin
                trials[nt] = data_out;
                nt++;
            end
            if (done) begin
                lat = e;
                break;
            end
        end
        check_val("latency", lat, 12);
        check_val("result", {24'd0, data_out}, {24'd0, exp});
        if (chk_trials) begin
            check_val("sample_cycles", nsamp, 1);
            check_val("trial_count", nt, 8);
            for (int i = 0; i < 8; i++)
                check_val($sformatf("trial%0d", i), {24'd0, trials[i]}, {24'd0, exp_tr[i]});
        end
        tick();
        if (chk_trials) begin
            check_val("done_pulse", {31'd0, done}, 0);
            check_val("busy_after", {31'd0, busy}, 0);
            check_val("hold_result", {24'd0, data_out}, {24'd0, exp});
        end
        start = 1'b0;
        repeat (16) tick();
    endtask

    initial begin
        int  v;
        int  gap;
        int  ndone;
        bit  seen;
        longint ex;

        resetb  = 1'b0;
        start   = 1'b1;
        cmp_sel = 1'b1;
        vin_uv  = 263200;

        // Reset held with start high
        repeat (5) tick();
        check_val("rst_data", {24'd0, data_out}, 0);
        check_val("rst_done", {31'd0, done}, 0);
        check_val("rst_sample", {31'd0, sample}, 0);
        check_val("rst_busy", {31'd0, busy}, 0);
        start = 1'b0;
        tick();
        resetb = 1'b1;
        repeat (3) tick();

        // Single conversion with trial sequence
        run_conv(263200, 8'd37, 1'b1);

        // Extremes
        run_conv(0,       8'd0,   1'b0);
        run_conv(1790000, 8'd254, 1'b0);
        run_conv(1850000, 8'd255, 1'b0);

        // Sweep
        for (int k = 0; k < 67; k++) begin
            v  = 263200 + 23200 * k;
            ex = (longint'(v) * 256) / 1800000;
            if (ex > 255) ex = 255;
            run_conv(v, 8'(ex), 1'b0);
        end

        // Back-to-back conversions with start held high
        vin_uv = 1000000;
        start  = 1'b1;
        seen   = 1'b0;
        for (int e = 0; e < 40 && !seen; e++) begin
            tick();
            if (done) seen = 1'b1;
        end
        check_val("b2b_first", {31'd0, seen}, 1);
        for (int p = 0; p < 2; p++) begin
            gap  = 0;
            seen = 1'b0;
            for (int e = 0; e < 40 && !seen; e++) begin
                tick();
                if (done) seen = 1'b1;
                else gap++;
            end
            check_val($sformatf("b2b_gap%0d", p), gap, 10);
            check_val($sformatf("b2b_res%0d", p), {24'd0, data_out}, 142);
        end
        start = 1'b0;
        repeat (30) tick();

        // Start dropped right after SAMPLE
        vin_uv = 500000;
        start  = 1'b1;
        seen   = 1'b0;
        for (int e = 0; e < 20 && !seen; e++) begin
            tick();
            if (sample) seen = 1'b1;
        end
        start = 1'b0;
        seen  = 1'b0;
        for (int e = 0; e < 40 && !seen; e++) begin
            tick();
            if (done) seen = 1'b1;
        end
        check_val("drop_done", {31'd0, seen}, 1);
        check_val("drop_res", {24'd0, data_out}, 71);
        repeat (10) tick();

        // Internal comparator path
        cmp_sel = 1'b0;
        run_conv(263200,  8'd37,  1'b0);
        run_conv(1790000, 8'd254, 1'b0);
        run_conv(1850000, 8'd255, 1'b0);
        run_conv(0,       8'd0,   1'b0);

        // q_out follows the selected comparator combinationally (data_out = 0 here)
        vin_uv  = 100000;
        cmp_sel = 1'b0;
        #1;
        check_val("q_int", {31'd0, q_out}, 1);
        cmp_sel = 1'b1;
        vin_uv  = 0;
        #1;
        check_val("q_ext0", {31'd0, q_out}, 0);
        vin_uv  = 100000;
        #1;
        check_val("q_ext1", {31'd0, q_out}, 1);
        tick();

        // Reset in the middle of a conversion
        vin_uv = 1000000;
        start  = 1'b1;
        repeat (6) tick();
        check_val("mid_busy", {31'd0, busy}, 1);
        start  = 1'b0;
        resetb = 1'b0;
        tick();
        check_val("mid_rst_busy", {31'd0, busy}, 0);
        check_val("mid_rst_data", {24'd0, data_out}, 0);
        check_val("mid_rst_done", {31'd0, done}, 0);
        resetb = 1'b1;
        ndone  = 0;
        for (int e = 0; e < 20; e++) begin
            tick();
            if (done) ndone++;
        end
        check_val("mid_rst_nodone", ndone, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sar_adc_ctrl.md
Name: sar_adc_ctrl

Overview:
Digital successive-approximation controller for the user-project 8-bit SAR ADC inside caravel, driven from mprj_io pins. It sequences sample and binary-search phases and drives the trial code to the capacitive DAC, which settles to data_out*VREF/2^SIZE. It reads a comparator result selectable between the on-chip comparator and an external pin, and reports the final code with a done pulse.

Parameters:
SIZE, 8, resolution in bits; width of data_out and length of the bit search.

Ports:
clock  in  1  system clock; all flops on rising edge
resetb  in  1  synchronous active-low reset
start  in  1  conversion request from the pad; asynchronous to clock, level-sensitive
cmp_int  in  1  on-chip comparator: 1 when INP > DAC voltage
cmp_ext  in  1  external comparator, same polarity
cmp_sel  in  1  comparator select: 1 = cmp_ext, 0 = cmp_int
data_out  out  SIZE  SAR register; trial code during conversion, result afterwards; drives the DAC
done  out  1  one-cycle end-of-conversion pulse
q_out  out  1  selected comparator value, combinational: cmp_sel ? cmp_ext : cmp_int
sample  out  1  track/hold control; high only in SAMPLE
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (resetb=0 at a clock edge) from any state, including mid-conversion: state=IDLE; data_out=0; done=0; sample=0; bit index=SIZE-1; start synchroniser flops cleared.
- Synchroniser: start passes through 2 flops to give start_s. A start rising at edge E is visible as start_s at edge E+2. cmp is not synchronised.
- Comparator: cmp = q_out. Rule: keep the trial bit iff cmp=1, i.e. input strictly above the DAC level.
- States: IDLE, SAMPLE, CONV, DONE.
  - IDLE: when start_s=1, go to SAMPLE and clear data_out to 0. Otherwise data_out holds the last result.
  - SAMPLE: lasts one cycle with sample=1. Next edge: data_out = 1<<(SIZE-1), index=SIZE-1, go to CONV.
  - CONV: at each edge, if cmp=0, clear bit[index].
    - If index>0: set bit[index-1] and decrement index.
    - If index=0: go to DONE.
    - Exactly SIZE comparison edges.
  - DONE: done=1 for exactly this one cycle, data_out holds the final code. Next edge goes to IDLE.
- Latency: start_s seen at edge N; done is high in the cycle after edge N+SIZE+1. From the pad: SIZE+4 edges.
- Start behaviour:
  - Deasserting start during SAMPLE/CONV/DONE has no effect; the conversion completes.
  - If start is still high on return to IDLE, a new conversion begins at the next edge (back-to-back).
  - done must fall even when start is held high; the driver drops start on done's falling edge.
- The DAC sees data_out directly and must settle within one clock. data_out changes only at clock edges.
- Final code c is the largest value with c*VREF/2^SIZE < Vin, saturating to 0 and to 2^SIZE-1.
- Exact equality Vin = c*LSB yields c-1. This is accepted behaviour, and benches avoid exact code boundaries.
- cmp_sel may change between conversions only. A mid-conversion change takes effect at the next comparison edge.

Test Plan:
Bench setup: behavioural model cmp_ext = (Vin > data_out*1.8/256), cmp_sel=1, VREF=1.8 V, SIZE=8, LSB=7.03125 mV.
- Reset: hold resetb=0 for 5 cycles with start=1 -> data_out=0, done=0, sample=0, busy=0. Assert resetb=0 mid-CONV -> IDLE next edge, data_out=0, no done.
- Single conversion, Vin=0.2632 V -> data_out=37 (0x25). Trial sequence 0x80, 0x40, 0x20, 0x30, 0x28, 0x24, 0x26, 0x25. done is a 1-cycle pulse 12 edges after the start pad rises. sample is high for exactly 1 cycle.
- Sweep: Vin from 0.2632 V in +0.0232 V steps for 67 conversions, start held until done falls each time -> every result equals floor(Vin/1.8*256).
- Extremes: Vin=0.0 V -> 0x00. Vin=1.79 V -> 254. Vin=1.85 V -> 255.
- Start held high continuously -> back-to-back conversions, each done pulse separated by SIZE+2 cycles. Start dropped after SAMPLE -> conversion still completes.
- cmp_sel=0 with cmp_int driven from the model and cmp_ext tied to 0 -> same codes as above. q_out follows the selected input in the same cycle.
